sort_engine: RTL and testbench
==============================

# sort_engine

Parametrised in-place insertion-sort engine for arrays in a word-addressed memory behind separate read and write channels (ar/r, aw/w/b). It generalises the first-generation sort circuit in three ways: a runtime base address with wrap-around, a runtime ordering mode (ascending/descending, signed/unsigned), and explicit size and response error reporting. Control, datapath and write handshake live in one module.

## Interface
- `ADDR_WDTH`, 4: memory word-address width.
- `DATA_WDTH`, 32: element width.
- `RESP_WDTH`, 1: response width; 0 = OKAY, any nonzero value = error.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: sampled only in IDLE.
- `arr_size` in ADDR_WDTH+1: element count, latched at start.
- `base_addr` in ADDR_WDTH: address of element 0, latched at start.
- `descending` in 1: 0 = ascending, 1 = descending; latched at start.
- `is_signed` in 1: 1 = two's-complement compare; latched at start.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: valid only while `done`=1.
- `ar_ready` in 1: read address accepted.
- `ar_valid` out 1: read address valid.
- `ar_address` out ADDR_WDTH: read address.
- `r_data` in DATA_WDTH: read data.
- `r_valid` in 1: read data valid.
- `r_resp` in RESP_WDTH: read response.
- `r_ready` out 1: engine ready to accept read data.
- `aw_ready` in 1: write address accepted.
- `aw_valid` out 1: write address valid.
- `aw_address` out ADDR_WDTH: write address.
- `w_ready` in 1: write data accepted.
- `w_valid` out 1: write data valid.
- `w_data` out DATA_WDTH: write data.
- `b_valid` in 1: write response valid.
- `b_resp` in RESP_WDTH: write response.
- `b_ready` out 1: engine ready to accept write response.

## Operation
- Addresses: element k is at `(base_addr + k) mod 2^ADDR_WDTH`.
- Out-of-order predicate OOO(c, key):
  - ascending: c > key.
  - descending: c < key.
  - Compare is signed or unsigned per the latched `is_signed`.
  - Equal elements never move, so the sort is stable.
- Registers: `i`, `j` (ADDR_WDTH+1 bits each), `key`, `cmp`, and the latched inputs.
- States and transitions:
  - **IDLE**: on `start`:
    - if `arr_size > 2^ADDR_WDTH`, go to DONE with err=1.
    - else if `arr_size < 2`, go to DONE with err=0.
    - else set i=1 and go to RD_KEY_A.
  - **RD_KEY_A**: `ar_valid`=1, address of element i. Go to RD_KEY_R on `ar_ready`.
  - **RD_KEY_R**: `r_ready`=1. On `r_valid`: key=`r_data`, j=i-1, go to RD_CMP_A.
  - **RD_CMP_A / RD_CMP_R**: same handshake, address of element j. On `r_valid`: cmp=`r_data`.
    - If OOO(cmp, key), go to WR_SHIFT.
    - Else if j+1 == i, go to NEXT (the key is already in place; no write).
    - Else go to WR_KEY.
  - **WR_SHIFT**: write cmp to element j+1.
    - Then, if j == 0, set j=-1 (all ones) and go to WR_KEY.
    - Else decrement j and go to RD_CMP_A.
  - **WR_KEY**: write key to element j+1, then go to NEXT.
  - **NEXT**: increment i. If i == arr_size go to DONE, else go to RD_KEY_A.
  - **DONE**: `done`=1 for one cycle, then go to IDLE.
- Write handshake (WR_SHIFT, WR_KEY):
  - On state entry, `aw_valid`=`w_valid`=1 with stable address and data.
  - Each valid drops independently in the cycle after its own ready is sampled.
  - `b_ready`=1 once both channels have been accepted.
  - The state completes on `b_valid`.
- Error: a nonzero `r_resp` (with `r_valid`) or `b_resp` (with `b_valid`) goes directly to DONE with err=1. No further transactions are issued and memory is left partially sorted.
- `start` while busy is ignored. Latched inputs are immune to changes during a sort.

## Timing
- Reset values: every output is 0 and the state is IDLE.
- Reset asserted mid-transaction drops all valids immediately.
- Outputs are Moore, decoded from registered state and registers.
- At most one transaction is outstanding at any time.
- `start` sampled at edge t:
  - the first `ar_valid` appears in cycle t+1;
  - for size/degenerate cases, `done` is high in cycle t+1.
- Zero-wait memory:
  - each read costs 2 cycles;
  - each write costs 2 cycles (address/data, then response);
  - NEXT costs 1 cycle.
- `busy` falls in the cycle after `done`.
- `ar_address`, `aw_address` and `w_data` are held constant while their valid is high.

## Test plan
- ADDR_WDTH=4, base 0, ascending unsigned, memory [3,1,2]:
  - result [1,2,3];
  - exactly 5 reads and 4 writes, in order: mem1←3, mem0←1, mem2←3, mem1←2;
  - done=1 with err=0.
- Already sorted [1,2,3,4]: 6 reads, 0 writes, done with err=0.
- Descending signed, [-1,5,0] (0xFFFFFFFF, 5, 0): result [5,0,-1]. The same data sorted ascending unsigned gives [0,5,0xFFFFFFFF].
- Base wrap: base_addr=14, arr_size=3. Read addresses touch only 14, 15 and 0; address 1 is never accessed.
- arr_size=17 (ADDR_WDTH=4): done and err high 1 cycle after start, with no valid ever asserted. arr_size=0 and arr_size=1: done with err=0, no bus activity.
- Stalls and errors:
  - aw_ready held off 3 cycles while w_ready is immediate: w_valid drops after 1 cycle, aw_valid stays high with a stable address, b_ready rises only after aw is accepted.
  - r_resp=1 on the second read: done with err=1, and no ar_valid afterwards.

Source files
------------

// File: rtl/sort_engine_if.sv
// Memory bus between the sort engine (master) and a word-addressed memory (slave):
// separate read (ar/r) and write (aw/w/b) channels.
interface sort_engine_if #(
  parameter int ADDR_WDTH = 4,
  parameter int DATA_WDTH = 32,
  parameter int RESP_WDTH = 1
);
  logic                 ar_ready;
  logic                 ar_valid;
  logic [ADDR_WDTH-1:0] ar_address;
  logic [DATA_WDTH-1:0] r_data;
  logic                 r_valid;
  logic [RESP_WDTH-1:0] r_resp;
  logic                 r_ready;
  logic                 aw_ready;
  logic                 aw_valid;
  logic [ADDR_WDTH-1:0] aw_address;
  logic                 w_ready;
  logic                 w_valid;
  logic [DATA_WDTH-1:0] w_data;
  logic                 b_valid;
  logic [RESP_WDTH-1:0] b_resp;
  logic                 b_ready;

  modport master (
    input  ar_ready, r_data, r_valid, r_resp, aw_ready, w_ready, b_valid, b_resp,
    output ar_valid, ar_address, r_ready, aw_valid, aw_address, w_valid, w_data, b_ready
  );

  modport slave (
    output ar_ready, r_data, r_valid, r_resp, aw_ready, w_ready, b_valid, b_resp,
    input  ar_valid, ar_address, r_ready, aw_valid, aw_address, w_valid, w_data, b_ready
  );
endinterface

// File: rtl/sort_engine.sv
// In-place insertion sort over a wrap-around window of word-addressed memory,
// with runtime ordering mode and size/response error reporting.
//
// state    | meaning
// IDLE     | waiting for start
// RD_KEY_A | read address for element i
// RD_KEY_R | waiting for key data
// RD_CMP_A | read address for element j
// RD_CMP_R | waiting for compare data, decide shift / place / skip
// WR_SHIFT | write cmp to element j+1
// WR_KEY   | write key to element j+1
// NEXT     | advance i
// DONE     | one-cycle completion pulse
module sort_engine #(
  parameter int ADDR_WDTH = 4,
  parameter int DATA_WDTH = 32,
  parameter int RESP_WDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_WDTH:0]   arr_size,
  input  logic [ADDR_WDTH-1:0] base_addr,
  input  logic                 descending,
  input  logic                 is_signed,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  sort_engine_if.master        bus
);
  typedef enum logic [3:0] {
    IDLE, RD_KEY_A, RD_KEY_R, RD_CMP_A, RD_CMP_R, WR_SHIFT, WR_KEY, NEXT, DONE
  } state_t;

  typedef logic [ADDR_WDTH:0]   idx_t;
  typedef logic [ADDR_WDTH-1:0] addr_t;
  typedef logic [DATA_WDTH-1:0] data_t;

  localparam idx_t IDX_ONE  = {{ADDR_WDTH{1'b0}}, 1'b1};
  localparam idx_t MAX_SIZE = {1'b1, {ADDR_WDTH{1'b0}}};

  state_t state_q, state_d;
  idx_t   i_q, i_d, j_q, j_d, size_q, size_d;
  data_t  key_q, key_d, cmp_q, cmp_d, w_data_q, w_data_d;
  addr_t  base_q, base_d, ar_addr_q, ar_addr_d, aw_addr_q, aw_addr_d;
  logic   desc_q, desc_d, sgn_q, sgn_d;
  logic   ar_valid_q, ar_valid_d, r_ready_q, r_ready_d;
  logic   aw_valid_q, aw_valid_d, w_valid_q, w_valid_d, b_ready_q, b_ready_d;
  logic   busy_q, busy_d, done_q, done_d, err_q, err_d;

  function automatic addr_t elem_addr(input addr_t b, input idx_t k);
    return b + k[ADDR_WDTH-1:0];
  endfunction

  // Signed order is unsigned order with the sign bits inverted.
  function automatic logic out_of_order(input data_t c, input data_t k,
                                        input logic dsc, input logic sgn);
    data_t cx, kx;
    cx = c;
    kx = k;
    cx[DATA_WDTH-1] = c[DATA_WDTH-1] ^ sgn;
    kx[DATA_WDTH-1] = k[DATA_WDTH-1] ^ sgn;
    return dsc ? (cx < kx) : (cx > kx);
  endfunction

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    size_d     = size_q;
    key_d      = key_q;
    cmp_d      = cmp_q;
    base_d     = base_q;
    desc_d     = desc_q;
    sgn_d      = sgn_q;
    ar_valid_d = ar_valid_q;
    ar_addr_d  = ar_addr_q;
    r_ready_d  = r_ready_q;
    aw_valid_d = aw_valid_q;
    aw_addr_d  = aw_addr_q;
    w_valid_d  = w_valid_q;
    w_data_d   = w_data_q;
    b_ready_d  = b_ready_q;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          size_d = arr_size;
          base_d = base_addr;
          desc_d = descending;
          sgn_d  = is_signed;
          if (arr_size > MAX_SIZE) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else if (arr_size < 2) begin
            state_d = DONE;
          end else begin
            i_d        = IDX_ONE;
            ar_valid_d = 1'b1;
            ar_addr_d  = elem_addr(base_addr, IDX_ONE);
            state_d    = RD_KEY_A;
          end
        end
      end
      RD_KEY_A, RD_CMP_A: begin
        if (bus.ar_ready) begin
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
          state_d    = (state_q == RD_KEY_A) ? RD_KEY_R : RD_CMP_R;
        end
      end
      RD_KEY_R: begin
        if (bus.r_valid) begin
          r_ready_d = 1'b0;
          if (|bus.r_resp) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            key_d      = bus.r_data;
            j_d        = i_q - IDX_ONE;
            ar_valid_d = 1'b1;
            ar_addr_d  = elem_addr(base_q, i_q - IDX_ONE);
            state_d    = RD_CMP_A;
          end
        end
      end
      RD_CMP_R: begin
        if (bus.r_valid) begin
          r_ready_d = 1'b0;
          cmp_d     = bus.r_data;
          if (|bus.r_resp) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else if (out_of_order(bus.r_data, key_q, desc_q, sgn_q)) begin
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            aw_addr_d  = elem_addr(base_q, j_q + IDX_ONE);
            w_data_d   = bus.r_data;
            state_d    = WR_SHIFT;
          end else if ((j_q + IDX_ONE) == i_q) begin
            state_d = NEXT;
          end else begin
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            aw_addr_d  = elem_addr(base_q, j_q + IDX_ONE);
            w_data_d   = key_q;
            state_d    = WR_KEY;
          end
        end
      end
      WR_SHIFT, WR_KEY: begin
        if (aw_valid_q && bus.aw_ready) aw_valid_d = 1'b0;
        if (w_valid_q && bus.w_ready) w_valid_d = 1'b0;
        b_ready_d = b_ready_q || (!aw_valid_d && !w_valid_d);
        if (b_ready_q && bus.b_valid) begin
          b_ready_d = 1'b0;
          if (|bus.b_resp) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else if (state_q == WR_KEY) begin
            state_d = NEXT;
          end else if (j_q == '0) begin
            // j wraps to all ones so that j+1 addresses element 0 for the key write.
            j_d        = '1;
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            aw_addr_d  = base_q;
            w_data_d   = key_q;
            state_d    = WR_KEY;
          end else begin
            j_d        = j_q - IDX_ONE;
            ar_valid_d = 1'b1;
            ar_addr_d  = elem_addr(base_q, j_q - IDX_ONE);
            state_d    = RD_CMP_A;
          end
        end
      end
      NEXT: begin
        i_d = i_q + IDX_ONE;
        if ((i_q + IDX_ONE) == size_q) begin
          state_d = DONE;
        end else begin
          ar_valid_d = 1'b1;
          ar_addr_d  = elem_addr(base_q, i_q + IDX_ONE);
          state_d    = RD_KEY_A;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      i_q        <= '0;
      j_q        <= '0;
      size_q     <= '0;
      key_q      <= '0;
      cmp_q      <= '0;
      base_q     <= '0;
      desc_q     <= 1'b0;
      sgn_q      <= 1'b0;
      ar_valid_q <= 1'b0;
      ar_addr_q  <= '0;
      r_ready_q  <= 1'b0;
      aw_valid_q <= 1'b0;
      aw_addr_q  <= '0;
      w_valid_q  <= 1'b0;
      w_data_q   <= '0;
      b_ready_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      size_q     <= size_d;
      key_q      <= key_d;
      cmp_q      <= cmp_d;
      base_q     <= base_d;
      desc_q     <= desc_d;
      sgn_q      <= sgn_d;
      ar_valid_q <= ar_valid_d;
      ar_addr_q  <= ar_addr_d;
      r_ready_q  <= r_ready_d;
      aw_valid_q <= aw_valid_d;
      aw_addr_q  <= aw_addr_d;
      w_valid_q  <= w_valid_d;
      w_data_q   <= w_data_d;
      b_ready_q  <= b_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign bus.ar_valid   = ar_valid_q;
  assign bus.ar_address = ar_addr_q;
  assign bus.r_ready    = r_ready_q;
  assign bus.aw_valid   = aw_valid_q;
  assign bus.aw_address = aw_addr_q;
  assign bus.w_valid    = w_valid_q;
  assign bus.w_data     = w_data_q;
  assign bus.b_ready    = b_ready_q;
endmodule

// File: tb/tb_sort_engine.sv
// Directed bench for sort_engine: a zero-wait memory slave with optional aw stall
// and read-error injection, plus a bus monitor feeding per-run statistics.
module tb_sort_engine;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [4:0] arr_size;
  logic [3:0] base_addr;
  logic       descending, is_signed;
  logic       busy, done, err;

  sort_engine_if #(.ADDR_WDTH(4), .DATA_WDTH(32), .RESP_WDTH(1)) bus ();

  sort_engine #(.ADDR_WDTH(4), .DATA_WDTH(32), .RESP_WDTH(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .arr_size(arr_size),
    .base_addr(base_addr), .descending(descending), .is_signed(is_signed),
    .busy(busy), .done(done), .err(err), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] mem [16];
  logic [3:0]  rd_q [$];
  logic [3:0]  wr_a_q [$];
  logic [31:0] wr_d_q [$];

  int ar_cyc, aw_cyc, w_cyc, b_cyc, b_early, aw_addr_chg, any_act, touched1;
  int aw_stall, err_rd;
  logic       rd_pend, aw_got, w_got, aw_prev_v;
  logic [3:0] rd_a, aw_a, aw_prev_a;
  logic [31:0] w_d;

  int   cycles;
  logic first_ar, first_done, err_at_done;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory slave and monitor, both acting away from the rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0; aw_prev_v = 1'b0;
      bus.r_valid = 1'b0; bus.b_valid = 1'b0; bus.aw_ready = 1'b0; bus.w_ready = 1'b0;
    end else begin
      if (bus.ar_valid) begin
        ar_cyc++;
        if (bus.ar_address == 4'd1) touched1++;
        rd_q.push_back(bus.ar_address);
        rd_pend = 1'b1;
        rd_a = bus.ar_address;
      end
      if (bus.aw_valid) begin
        aw_cyc++;
        if (aw_prev_v && bus.aw_address != aw_prev_a) aw_addr_chg++;
      end
      aw_prev_v = bus.aw_valid;
      aw_prev_a = bus.aw_address;
      if (bus.w_valid) w_cyc++;
      if (bus.b_ready) begin
        b_cyc++;
        if (bus.aw_valid || bus.w_valid) b_early++;
      end
      if (bus.ar_valid || bus.aw_valid || bus.w_valid || bus.r_ready || bus.b_ready) any_act++;

      if (bus.r_ready && rd_pend) begin
        bus.r_valid = 1'b1;
        bus.r_data  = mem[rd_a];
        bus.r_resp  = (rd_q.size() == err_rd) ? 1'b1 : 1'b0;
        rd_pend = 1'b0;
      end else begin
        bus.r_valid = 1'b0;
        bus.r_resp  = 1'b0;
      end

      if (bus.aw_valid && !aw_got) begin
        if (aw_stall > 0) begin
          bus.aw_ready = 1'b0;
          aw_stall--;
        end else begin
          bus.aw_ready = 1'b1;
          aw_got = 1'b1;
          aw_a = bus.aw_address;
        end
      end else bus.aw_ready = 1'b0;

      if (bus.w_valid && !w_got) begin
        bus.w_ready = 1'b1;
        w_got = 1'b1;
        w_d = bus.w_data;
      end else bus.w_ready = 1'b0;

      if (bus.b_ready && aw_got && w_got) begin
        bus.b_valid = 1'b1;
        mem[aw_a] = w_d;
        wr_a_q.push_back(aw_a);
        wr_d_q.push_back(w_d);
        if (aw_a == 4'd1) touched1++;
        aw_got = 1'b0;
        w_got = 1'b0;
      end else bus.b_valid = 1'b0;
    end
  end

  task automatic clear_stats();
    rd_q.delete(); wr_a_q.delete(); wr_d_q.delete();
    ar_cyc = 0; aw_cyc = 0; w_cyc = 0; b_cyc = 0; b_early = 0;
    aw_addr_chg = 0; any_act = 0; touched1 = 0;
  endtask

  task automatic fill_mem();
    for (int k = 0; k < 16; k++) mem[k] = 32'hDEAD_0000 + k;
  endtask

  task automatic run(input logic [4:0] size, input logic [3:0] base,
                     input logic dsc, input logic sgn);
    @(negedge clk);
    clear_stats();
    arr_size = size; base_addr = base; descending = dsc; is_signed = sgn;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Scramble the inputs to show they were latched.
    arr_size = 5'd0; base_addr = ~base; descending = ~dsc; is_signed = ~sgn;
    first_ar = bus.ar_valid;
    first_done = done;
    cycles = 1;
    while (!done && cycles < 500) begin
      @(negedge clk);
      cycles++;
      start = (cycles == 3);
    end
    start = 1'b0;
    chk("done_reached", done, 1'b1);
    err_at_done = err;
    @(negedge clk);
    chk("busy_done_fall", {busy, done, err}, 3'b000);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; arr_size = '0; base_addr = '0;
    descending = 1'b0; is_signed = 1'b0;
    bus.ar_ready = 1'b1; bus.r_valid = 1'b0; bus.r_data = '0; bus.r_resp = '0;
    bus.aw_ready = 1'b0; bus.w_ready = 1'b0; bus.b_valid = 1'b0; bus.b_resp = '0;
    aw_stall = 0; err_rd = 0;
    clear_stats();
    fill_mem();
    repeat (2) @(negedge clk);
    chk("reset_outputs", {busy, done, err, bus.ar_valid, bus.r_ready, bus.aw_valid,
                          bus.w_valid, bus.b_ready, bus.ar_address, bus.aw_address, bus.w_data}, '0);
    rst_n = 1'b1;

    // [3,1,2] ascending unsigned
    mem[0] = 3; mem[1] = 1; mem[2] = 2;
    run(5'd3, 4'd0, 1'b0, 1'b0);
    chk("t1_first_ar", first_ar, 1'b1);
    chk("t1_err", err_at_done, 1'b0);
    chk("t1_result", {mem[0], mem[1], mem[2]}, {32'd1, 32'd2, 32'd3});
    chk("t1_reads", rd_q.size(), 5);
    chk("t1_rd_seq", {rd_q[0], rd_q[1], rd_q[2], rd_q[3], rd_q[4]}, {4'd1, 4'd0, 4'd2, 4'd1, 4'd0});
    chk("t1_writes", wr_a_q.size(), 4);
    chk("t1_wr_addr", {wr_a_q[0], wr_a_q[1], wr_a_q[2], wr_a_q[3]}, {4'd1, 4'd0, 4'd2, 4'd1});
    chk("t1_wr_data", {wr_d_q[0][7:0], wr_d_q[1][7:0], wr_d_q[2][7:0], wr_d_q[3][7:0]},
        {8'd3, 8'd1, 8'd3, 8'd2});
    chk("t1_cycles", cycles, 21);

    // already sorted
    fill_mem();
    mem[0] = 1; mem[1] = 2; mem[2] = 3; mem[3] = 4;
    run(5'd4, 4'd0, 1'b0, 1'b0);
    chk("t2_reads", rd_q.size(), 6);
    chk("t2_writes", wr_a_q.size(), 0);
    chk("t2_err", err_at_done, 1'b0);
    chk("t2_cycles", cycles, 16);

    // descending signed, then ascending unsigned on the same data
    mem[0] = 32'hFFFF_FFFF; mem[1] = 5; mem[2] = 0;
    run(5'd3, 4'd0, 1'b1, 1'b1);
    chk("t3_desc_signed", {mem[0], mem[1], mem[2]}, {32'd5, 32'd0, 32'hFFFF_FFFF});
    mem[0] = 32'hFFFF_FFFF; mem[1] = 5; mem[2] = 0;
    run(5'd3, 4'd0, 1'b0, 1'b0);
    chk("t3_asc_unsigned", {mem[0], mem[1], mem[2]}, {32'd0, 32'd5, 32'hFFFF_FFFF});

    // base wrap
    fill_mem();
    mem[14] = 9; mem[15] = 7; mem[0] = 8; mem[1] = 32'hAA;
    run(5'd3, 4'd14, 1'b0, 1'b0);
    chk("t4_result", {mem[14], mem[15], mem[0]}, {32'd7, 32'd8, 32'd9});
    chk("t4_untouched", {touched1[7:0], mem[1]}, {8'd0, 32'hAA});
    begin
      int bad = 0;
      foreach (rd_q[k]) if (!(rd_q[k] inside {4'd14, 4'd15, 4'd0})) bad++;
      chk("t4_rd_window", bad, 0);
    end

    // size and degenerate cases
    run(5'd17, 4'd0, 1'b0, 1'b0);
    chk("t5_size17", {first_done, err_at_done, any_act[7:0]}, {1'b1, 1'b1, 8'd0});
    run(5'd0, 4'd3, 1'b0, 1'b0);
    chk("t5_size0", {first_done, err_at_done, any_act[7:0]}, {1'b1, 1'b0, 8'd0});
    run(5'd1, 4'd3, 1'b0, 1'b0);
    chk("t5_size1", {first_done, err_at_done, any_act[7:0]}, {1'b1, 1'b0, 8'd0});

    // aw stalled 3 cycles on the first write
    mem[0] = 2; mem[1] = 1;
    aw_stall = 3;
    run(5'd2, 4'd0, 1'b0, 1'b0);
    chk("t6_result", {mem[0], mem[1]}, {32'd1, 32'd2});
    chk("t6_w_cyc", w_cyc, 2);
    chk("t6_aw_cyc", aw_cyc, 5);
    chk("t6_aw_addr_stable", aw_addr_chg, 0);
    chk("t6_b_early", b_early, 0);
    chk("t6_b_cyc", b_cyc, 2);
    chk("t6_cycles", cycles, 13);

    // read error on the second read
    mem[0] = 3; mem[1] = 1; mem[2] = 2;
    err_rd = 2;
    run(5'd3, 4'd0, 1'b0, 1'b0);
    err_rd = 0;
    chk("t7_err", err_at_done, 1'b1);
    chk("t7_ar_cyc", ar_cyc, 2);
    chk("t7_no_write", {aw_cyc[7:0], wr_a_q.size()}, '0);
    chk("t7_mem_kept", {mem[0], mem[1], mem[2]}, {32'd3, 32'd1, 32'd2});

    // asynchronous reset during a write
    @(negedge clk);
    arr_size = 5'd3; base_addr = 4'd0; descending = 1'b0; is_signed = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      int waited = 0;
      while (!bus.aw_valid && waited < 50) begin
        @(negedge clk);
        waited++;
      end
      chk("t8_aw_seen", bus.aw_valid, 1'b1);
    end
    #2 rst_n = 1'b0;
    #1 chk("t8_async_reset", {busy, done, err, bus.ar_valid, bus.r_ready, bus.aw_valid,
                              bus.w_valid, bus.b_ready}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
